// File: rtl/esp32_boot_pkg.sv
`default_nettype none
// ============================================================================
// esp32_boot_pkg : shared types and constants for the ESP32 boot sequencer
// Revision 1.0
// ============================================================================
package esp32_boot_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT_RST = 2'd1,
    STRAP_HOLD = 2'd2,
    RUN        = 2'd3
  } boot_state_e;

  // Larger value wins when several sources fire in the same cycle.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_SOFT = 2'd1;
  localparam logic [1:0] SRC_HOST = 2'd2;
  localparam logic [1:0] SRC_BTN  = 2'd3;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_DL     = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [1:0] src;
    logic       dl;
  } boot_req_t;

  function automatic boot_req_t pick_request(
    input logic btn_ev,  input logic btn_dl,
    input logic host_ev, input logic host_dl,
    input logic soft_ev, input logic soft_dl
  );
    boot_req_t r;
    r = '{valid: 1'b0, src: SRC_NONE, dl: MODE_NORMAL};
    if (btn_ev)       r = '{valid: 1'b1, src: SRC_BTN,  dl: btn_dl};
    else if (host_ev) r = '{valid: 1'b1, src: SRC_HOST, dl: host_dl};
    else if (soft_ev) r = '{valid: 1'b1, src: SRC_SOFT, dl: soft_dl};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esp32_boot_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : synchroniser + stability counter for an active-low button
// Revision 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES  = 160000,
  parameter int HOST_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_fall
);

  localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [HOST_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DBC_W-1:0]            cnt_q, cnt_d;
  logic                        level_q, level_d;
  logic                        fall_q, fall_d;
  logic                        w_sample;

  assign w_sample = sync_q[HOST_SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i_btn_n;
    for (int i = 1; i < HOST_SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // The count restarts whenever the sample agrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (w_sample != level_q) begin
      if (cnt_q == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = w_sample;
        fall_d  = ~w_sample;
      end else begin
        cnt_d = cnt_q + DBC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/esp32_boot_sequencer.sv
`default_nettype none
// ============================================================================
// esp32_boot_sequencer : timed EN / IO0 sequencing for the NINA ESP32
// Revision 1.0
// ============================================================================
module esp32_boot_sequencer
  import esp32_boot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 160000,
  parameter int RESET_HOLD_CYCLES = 800000,
  parameter int STRAP_HOLD_CYCLES = 400000,
  parameter int HOST_SYNC_STAGES  = 2,
  parameter int CNT_W             = 20
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iRESET_BTN_N,
  input  logic iBOOT_BTN_N,
  input  logic iHOST_DTR_N,
  input  logic iHOST_RTS_N,
  input  logic iSOFT_REQ,
  input  logic iSOFT_DL,
  output logic oESP_EN,
  output logic oESP_IO0,
  output logic oUART_GATE,
  output logic oBUSY,
  output logic oDL_MODE,
  output logic oDONE
);

  boot_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        dl_q, dl_d;
  logic [HOST_SYNC_STAGES-1:0] dtr_sync_q, dtr_sync_d, rts_sync_q, rts_sync_d;
  logic                        rst_c_q;
  logic en_q, en_d, io0_q, io0_d, gate_q, gate_d;
  logic busy_q, busy_d, dl_mode_q, dl_mode_d, done_q, done_d;

  logic w_reset_level, w_reset_fall, w_boot_level, w_boot_fall, w_unused_btn;
  logic w_dtr_n, w_rts_n, w_rst_c, w_host_ev, w_host_dl;
  boot_req_t w_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOST_SYNC_STAGES(HOST_SYNC_STAGES))
    u_reset_btn (.clk(iCLK), .rst(iRESET), .i_btn_n(iRESET_BTN_N),
                 .o_level(w_reset_level), .o_fall(w_reset_fall));

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOST_SYNC_STAGES(HOST_SYNC_STAGES))
    u_boot_btn (.clk(iCLK), .rst(iRESET), .i_btn_n(iBOOT_BTN_N),
                .o_level(w_boot_level), .o_fall(w_boot_fall));

  assign w_unused_btn = w_reset_level ^ w_boot_fall;

  always_comb begin
    dtr_sync_d    = dtr_sync_q;
    rts_sync_d    = rts_sync_q;
    dtr_sync_d[0] = iHOST_DTR_N;
    rts_sync_d[0] = iHOST_RTS_N;
    for (int i = 1; i < HOST_SYNC_STAGES; i++) begin
      dtr_sync_d[i] = dtr_sync_q[i-1];
      rts_sync_d[i] = rts_sync_q[i-1];
    end
  end

  // Auto-reset style: RTS low with DTR high holds the ESP32; its release starts a sequence.
  assign w_dtr_n   = dtr_sync_q[HOST_SYNC_STAGES-1];
  assign w_rts_n   = rts_sync_q[HOST_SYNC_STAGES-1];
  assign w_rst_c   = ~w_rts_n & w_dtr_n;
  assign w_host_ev = rst_c_q & ~w_rst_c;
  assign w_host_dl = ~w_dtr_n & w_rts_n;

  assign w_req = pick_request(w_reset_fall, ~w_boot_level, w_host_ev, w_host_dl,
                              iSOFT_REQ, iSOFT_DL);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= ASSERT_RST;
      cnt_q      <= '0;
      dl_q       <= MODE_NORMAL;
      dtr_sync_q <= '1;
      rts_sync_q <= '1;
      rst_c_q    <= 1'b0;
      en_q       <= 1'b0;
      io0_q      <= 1'b1;
      gate_q     <= 1'b0;
      busy_q     <= 1'b1;
      dl_mode_q  <= MODE_NORMAL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dl_q       <= dl_d;
      dtr_sync_q <= dtr_sync_d;
      rts_sync_q <= rts_sync_d;
      rst_c_q    <= w_rst_c;
      en_q       <= en_d;
      io0_q      <= io0_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      dl_mode_q  <= dl_mode_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    unique case (state_q)
      IDLE: begin
        if (w_req.valid) begin
          state_d = ASSERT_RST;
          cnt_d   = '0;
          dl_d    = w_req.dl;
        end
      end
      ASSERT_RST: begin
        if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d = STRAP_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STRAP_HOLD: begin
        if (cnt_q == CNT_W'(STRAP_HOLD_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A button press restarts the sequence from any state.
    if (w_req.valid && w_req.src == SRC_BTN) begin
      state_d = ASSERT_RST;
      cnt_d   = '0;
      dl_d    = w_req.dl;
    end
  end

  // Decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    en_d      = 1'b1;
    io0_d     = 1'b1;
    gate_d    = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dl_mode_d = dl_mode_q;
    unique case (state_d)
      ASSERT_RST: begin
        en_d   = 1'b0;
        io0_d  = ~dl_d;
        gate_d = 1'b0;
        busy_d = 1'b1;
      end
      STRAP_HOLD: begin
        io0_d  = ~dl_d;
        busy_d = 1'b1;
      end
      RUN: begin
        done_d    = 1'b1;
        dl_mode_d = dl_d;
      end
      default: ;
    endcase
  end

  assign oESP_EN    = en_q;
  assign oESP_IO0   = io0_q;
  assign oUART_GATE = gate_q;
  assign oBUSY      = busy_q;
  assign oDL_MODE   = dl_mode_q;
  assign oDONE      = done_q;

endmodule
`default_nettype wire

// File: doc/esp32_boot_sequencer.md
Name: esp32_boot_sequencer

Overview:
- Drives the NINA ESP32 EN (reset) and IO0 (boot strap) lines with timed sequences.
- Enters either normal run or serial-download mode.
- Requests come from the MKR buttons, from the host DTR/RTS modem lines on the header UART, or from a soft request issued by the Avalon register file.
- Sits between the pin map and the ESP32 UART pass-through, and gates the pass-through while the ESP32 is held in reset.

Parameters:
DEBOUNCE_CYCLES, 160000, cycles a button must stay stable before its level is accepted (20 ms at 8 MHz)
RESET_HOLD_CYCLES, 800000, cycles EN is held low
STRAP_HOLD_CYCLES, 400000, cycles IO0 stays at its strap value after EN rises
HOST_SYNC_STAGES, 2, synchroniser depth for asynchronous inputs
CNT_W, 20, width of the shared hold counter; must hold the larger of the two hold parameters

Ports:
iCLK  in  1  system clock; the single clock domain
iRESET  in  1  synchronous reset, active-high
iRESET_BTN_N  in  1  reset button, active-low, asynchronous
iBOOT_BTN_N  in  1  boot button, active-low, asynchronous
iHOST_DTR_N  in  1  header DTR, active-low, asynchronous
iHOST_RTS_N  in  1  header RTS, active-low, asynchronous
iSOFT_REQ  in  1  one-cycle request pulse from the register file
iSOFT_DL  in  1  mode for iSOFT_REQ: 1 = download, 0 = normal; sampled with iSOFT_REQ
oESP_EN  out  1  ESP32 EN pin; 0 = held in reset
oESP_IO0  out  1  ESP32 IO0 strap; 0 = download
oUART_GATE  out  1  1 = header/ESP UART pass-through enabled
oBUSY  out  1  sequence in progress
oDL_MODE  out  1  last completed sequence was a download sequence
oDONE  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset values (while iRESET is high): oESP_EN=0, oESP_IO0=1, oUART_GATE=0, oBUSY=1, oDL_MODE=0, oDONE=0, counter=0.
- On iRESET deassertion the FSM enters ASSERT_RST with mode normal. A power-on normal boot is therefore automatic.
- Async inputs pass through a HOST_SYNC_STAGES flip-flop synchroniser. Buttons are then debounced.
  - Debounce: accept the new level after DEBOUNCE_CYCLES consecutive equal samples.
  - Reset press event = debounced reset-button falling edge.
- Host condition rst_c = (RTS asserted & DTR deasserted), using synchronised lines.
  - Host event fires on the falling edge of rst_c.
  - Host mode = download if (DTR asserted & RTS deasserted) in the same cycle rst_c falls; otherwise normal.
- Request sources:
  - Button press: mode = download if the debounced boot button is low at the press cycle.
  - Soft request: mode = iSOFT_DL.
  - Priority when several fire in the same cycle: button > host > soft.
- FSM states: IDLE, ASSERT_RST, STRAP_HOLD, RUN.
  - IDLE: EN=1, IO0=1, GATE=1, BUSY=0. Any request -> ASSERT_RST with its mode latched; counter cleared.
  - ASSERT_RST: EN=0, IO0 = ~dl, GATE=0, BUSY=1. Counter increments. When counter == RESET_HOLD_CYCLES-1 -> STRAP_HOLD, counter cleared.
  - STRAP_HOLD: EN=1, IO0 = ~dl, GATE=1, BUSY=1. When counter == STRAP_HOLD_CYCLES-1 -> RUN.
  - RUN: single cycle. oDONE=1; oDL_MODE updated to the latched mode; EN=1, IO0=1, BUSY=0. Then -> IDLE.
- Total latency from request cycle to oDONE = 1 + RESET_HOLD_CYCLES + STRAP_HOLD_CYCLES cycles.
- Requests while busy:
  - Host and soft requests while BUSY are dropped (not queued).
  - A button press while BUSY aborts: -> ASSERT_RST with the new mode and counter cleared. oDL_MODE is unchanged.
- All outputs are registered. oDL_MODE holds its value until the next RUN.

Decomposition:
- Package esp32_boot_pkg holds:
  - state enum {IDLE, ASSERT_RST, STRAP_HOLD, RUN};
  - source priority constants;
  - MODE_NORMAL=0, MODE_DL=1.
- Sub-module btn_debounce (parameters DEBOUNCE_CYCLES, HOST_SYNC_STAGES): synchroniser, stable counter, debounced level and falling-edge pulse. Instantiated twice.

Test Plan (run with DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=10, STRAP_HOLD_CYCLES=6):
1. Release iRESET -> EN=0, IO0=1 for 10 cycles; EN=1 for 6 cycles; oDONE pulse; oDL_MODE=0; then IDLE with GATE=1.
2. Hold boot button low, press reset button for 8 cycles -> EN low for 10 cycles and IO0=0 throughout ASSERT_RST+STRAP_HOLD; oDL_MODE=1; oDONE fires 17 cycles after the debounced press.
3. Host sequence RTS=0, DTR=1, then RTS=1, DTR=0 in the same cycle -> download sequence. A second sequence RTS=0, DTR=1, then both deasserted -> normal sequence; oDL_MODE returns to 0.
4. Reset-button glitch of 3 cycles -> no sequence; EN stays 1.
5. iSOFT_REQ with iSOFT_DL=1 in the same cycle as a host normal event -> host wins (normal). A soft request during STRAP_HOLD is ignored; exactly one oDONE.
6. Button press at ASSERT_RST counter=5 -> counter restarts; EN stays low for a further full 10 cycles; oDONE only once. Asserting iRESET mid-STRAP_HOLD -> outputs return to reset values on the next cycle.
